// File: rtl/tape_ear_filter.sv
// Tape/EAR input conditioner: synchronises the comparator pin, rejects short glitches,
// measures the spacing of accepted edges and reports tape activity to the ULA side.
module tape_ear_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4,
    parameter int PW_WIDTH      = 16,
    parameter int ACT_TIMEOUT   = 3500000
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                ear_raw,
    input  logic                invert,
    output logic                ear,
    output logic                ear_edge,
    output logic [PW_WIDTH-1:0] pulse_len,
    output logic                pulse_valid,
    output logic                active
);

    localparam int DCNT_W = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam int IDLE_W = $clog2(ACT_TIMEOUT + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(GLITCH_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(ACT_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DCNT_W-1:0]      r_dcnt;
    logic                   r_ear;
    logic                   r_ear_edge;
    logic [PW_WIDTH-1:0]    r_cyc;
    logic [PW_WIDTH-1:0]    r_pulse_len;
    logic                   r_pulse_valid;
    logic [IDLE_W-1:0]      r_idle;
    logic                   r_active;

    logic                   w_s;
    logic                   w_diff;
    logic                   w_accept;
    logic [PW_WIDTH-1:0]    w_cyc_sat;

    // Polarity is quasi-static, so it is applied after the chain rather than synchronised.
    assign w_s       = r_sync[SYNC_STAGES-1] ^ invert;
    assign w_diff    = (w_s != r_ear);
    assign w_accept  = w_diff && (r_dcnt == DCNT_LAST);
    assign w_cyc_sat = (r_cyc == {PW_WIDTH{1'b1}}) ? r_cyc : r_cyc + 1'b1;

    // NOTE: every state register uses <= so all blocks see pre-edge values of each other.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ear_raw};
        end
    end

    // A new level must disagree with ear for GLITCH_CYCLES consecutive clocks to be taken.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_dcnt     <= '0;
            r_ear      <= 1'b0;
            r_ear_edge <= 1'b0;
        end else begin
            r_ear_edge <= w_accept;
            if (!w_diff) begin
                r_dcnt <= '0;
            end else if (w_accept) begin
                r_ear  <= w_s;
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end
    end

    // pulse_len reports sat(cyc+1) so edges N clocks apart read back as exactly N.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cyc         <= '0;
            r_pulse_len   <= '0;
            r_pulse_valid <= 1'b0;
        end else begin
            r_pulse_valid <= w_accept && r_active;
            if (w_accept) begin
                r_pulse_len <= w_cyc_sat;
                r_cyc       <= '0;
            end else begin
                r_cyc <= w_cyc_sat;
            end
        end
    end

    // An accepted edge reloads the idle timer and wins over a coincident timeout.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_idle   <= '0;
            r_active <= 1'b0;
        end else if (w_accept) begin
            r_idle   <= IDLE_LOAD;
            r_active <= 1'b1;
        end else if (r_idle != '0) begin
            r_idle <= r_idle - 1'b1;
            if (r_idle == IDLE_ONE) begin
                r_active <= 1'b0;
            end
        end
    end

    assign ear         = r_ear;
    assign ear_edge    = r_ear_edge;
    assign pulse_len   = r_pulse_len;
    assign pulse_valid = r_pulse_valid;
    assign active      = r_active;

    a_valid_needs_edge : assert property (@(posedge clk) disable iff (!nreset)
        r_pulse_valid |-> r_ear_edge);

    if (GLITCH_CYCLES >= 2) begin : g_edge_spacing
        a_no_double_edge : assert property (@(posedge clk) disable iff (!nreset)
            r_ear_edge |=> !r_ear_edge);
    end

endmodule
